// File: rtl/pci_arb_pkg.sv
// Shared definitions for the PCI round-robin arbiter.
// Holds the arbiter state encoding, the default sizing parameters, and the
// bus-idle helper that both the arbiter and its tests agree on.
package pci_arb_pkg;

  localparam int N_MASTERS_DFLT    = 8;
  localparam int IDLE_TIMEOUT_DFLT = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRANT  = 3'd1,
    ST_PARK   = 3'd2,
    ST_BUSY   = 3'd3,
    ST_SWITCH = 3'd4
  } arb_state_e;

  // The PCI bus is idle only when neither FRAME# nor IRDY# is asserted.
  function automatic logic bus_idle(input logic frame_n, input logic irdy_n);
    return frame_n & irdy_n;
  endfunction

endpackage

// File: rtl/pci_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
// Ports:
//   i_req  - request vector, active high, one bit per master
//   i_last - index of the master that won last; search starts at i_last+1
//   o_sel  - first requesting index found in wrap-around order
//   o_any  - high when any request bit is set
module rr_pick
  import pci_arb_pkg::*;
#(
  parameter int N_MASTERS = N_MASTERS_DFLT
) (
  input  logic [N_MASTERS-1:0]         i_req,
  input  logic [$clog2(N_MASTERS)-1:0] i_last,
  output logic [$clog2(N_MASTERS)-1:0] o_sel,
  output logic                         o_any
);

  localparam int IDX_W = $clog2(N_MASTERS);

  logic [IDX_W-1:0] w_idx;

  // Walk last+1 .. last+N (mod N) and keep the first requester seen.
  always_comb begin
    o_sel = '0;
    o_any = 1'b0;
    w_idx = '0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      w_idx = IDX_W'((int'(i_last) + i) % N_MASTERS);
      if (!o_any && i_req[w_idx]) begin
        o_any = 1'b1;
        o_sel = w_idx;
      end else begin
        o_any = o_any;
      end
    end
  end

endmodule

// File: rtl/pci_rr_arbiter.sv
// pci_rr_arbiter: round-robin central arbiter for a shared PCI bus.
// Ports:
//   clk, rst_n   - bus clock (rising edge), asynchronous active-low reset
//   req_n        - per-master request, active low
//   frame_n      - global FRAME#, active low
//   irdy_n       - global IRDY#, active low
//   gnt_n        - per-master grant, active low, at most one bit low
//   owner        - index of the current (or most recent) bus owner
//   owner_valid  - high while a transaction by owner is in progress
// Every change of grant between two masters goes through SWITCH, which
// holds all grants high for one clock so two initiators never overlap.
module pci_rr_arbiter
  import pci_arb_pkg::*;
#(
  parameter int N_MASTERS    = N_MASTERS_DFLT,
  parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DFLT,
  parameter bit PARK_EN      = 1'b1,
  parameter int PARK_DEFAULT = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_MASTERS-1:0]         req_n,
  input  logic                         frame_n,
  input  logic                         irdy_n,
  output logic [N_MASTERS-1:0]         gnt_n,
  output logic [$clog2(N_MASTERS)-1:0] owner,
  output logic                         owner_valid
);

  localparam int                IDX_W    = $clog2(N_MASTERS);
  localparam int                CNT_W    = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(IDLE_TIMEOUT);
  localparam logic [IDX_W-1:0]  PARK_IDX = IDX_W'(PARK_DEFAULT);
  localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(N_MASTERS - 1);

  function automatic logic [N_MASTERS-1:0] onehot(input logic [IDX_W-1:0] idx);
    return {{(N_MASTERS-1){1'b0}}, 1'b1} << idx;
  endfunction

  arb_state_e             r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_last, w_last_nxt;
  logic [IDX_W-1:0]       r_sel, w_sel_nxt;
  logic [IDX_W-1:0]       r_owner, w_owner_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [N_MASTERS-1:0]   r_gnt_n, w_gnt_nxt;
  logic                   r_owner_valid, w_ov_nxt;
  logic                   r_owned, w_owned_nxt;

  logic [N_MASTERS-1:0]   w_req;
  logic                   w_bus_idle;
  logic [IDX_W-1:0]       w_pick;
  logic                   w_any;
  logic                   w_other;
  logic [CNT_W-1:0]       w_cnt_inc;
  logic [IDX_W-1:0]       w_park_idx;

  assign w_req      = ~req_n;
  assign w_bus_idle = bus_idle(frame_n, irdy_n);
  // Requests from anyone other than the master currently granted/owning.
  assign w_other    = |(w_req & ~onehot(r_sel));
  assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
  // Park on the last real owner; before anyone has owned the bus use the default.
  assign w_park_idx = r_owned ? r_owner : PARK_IDX;

  rr_pick #(.N_MASTERS(N_MASTERS)) u_pick (
    .i_req  (w_req),
    .i_last (r_last),
    .o_sel  (w_pick),
    .o_any  (w_any)
  );

  // Next-state and next-output decode; grants default to all released.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_sel_nxt   = r_sel;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    w_gnt_nxt   = '1;
    w_ov_nxt    = r_owner_valid;
    w_owned_nxt = r_owned;
    case (r_state)
      ST_IDLE, ST_SWITCH: begin
        if (!frame_n) begin
          // FRAME# with no grant outstanding: hold here, keep everyone off.
          w_state_nxt = r_state;
        end else if (w_any) begin
          w_state_nxt = ST_GRANT;
          w_sel_nxt   = w_pick;
          w_cnt_nxt   = '0;
          w_gnt_nxt   = ~onehot(w_pick);
        end else if (PARK_EN) begin
          w_state_nxt = ST_PARK;
          w_sel_nxt   = w_park_idx;
          w_gnt_nxt   = ~onehot(w_park_idx);
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!frame_n) begin
          w_state_nxt = ST_BUSY;
          w_owner_nxt = r_sel;
          w_last_nxt  = r_sel;
          w_ov_nxt    = 1'b1;
          w_owned_nxt = 1'b1;
          w_gnt_nxt   = w_other ? '1 : ~onehot(r_sel);
        end else if (!w_req[r_sel]) begin
          w_state_nxt = ST_SWITCH;
        end else if (w_bus_idle && (w_cnt_inc == CNT_MAX)) begin
          // Revoke the unused grant and move the pointer past this master.
          w_state_nxt = ST_SWITCH;
          w_last_nxt  = r_sel;
        end else begin
          w_gnt_nxt = ~onehot(r_sel);
          w_cnt_nxt = w_bus_idle ? w_cnt_inc : r_cnt;
        end
      end
      ST_PARK: begin
        if (!frame_n) begin
          w_state_nxt = ST_BUSY;
          w_owner_nxt = r_sel;
          w_last_nxt  = r_sel;
          w_ov_nxt    = 1'b1;
          w_owned_nxt = 1'b1;
          w_gnt_nxt   = w_other ? '1 : ~onehot(r_sel);
        end else if (w_other) begin
          w_state_nxt = ST_SWITCH;
        end else begin
          w_gnt_nxt = ~onehot(r_sel);
        end
      end
      ST_BUSY: begin
        if (w_bus_idle) begin
          w_ov_nxt = 1'b0;
          if (w_other) begin
            w_state_nxt = ST_SWITCH;
          end else if (PARK_EN) begin
            w_state_nxt = ST_PARK;
            w_sel_nxt   = r_owner;
            w_gnt_nxt   = ~onehot(r_owner);
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          // Pull the grant early when someone else waits; owner still finishes.
          w_gnt_nxt = w_other ? '1 : ~onehot(r_owner);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops all grants immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_last        <= LAST_RST;
      r_sel         <= '0;
      r_owner       <= '0;
      r_cnt         <= '0;
      r_gnt_n       <= '1;
      r_owner_valid <= 1'b0;
      r_owned       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_last        <= w_last_nxt;
      r_sel         <= w_sel_nxt;
      r_owner       <= w_owner_nxt;
      r_cnt         <= w_cnt_nxt;
      r_gnt_n       <= w_gnt_nxt;
      r_owner_valid <= w_ov_nxt;
      r_owned       <= w_owned_nxt;
    end
  end

  assign gnt_n       = r_gnt_n;
  assign owner       = r_owner;
  assign owner_valid = r_owner_valid;

endmodule
